// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial framed program loader driving the instruction-memory write port
module imem_loader #(
    parameter int          ADDR_W  = 9,
    parameter logic [7:0]  MAGIC   = 8'hA5,
    parameter int          TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              ImemWrite,
    output logic [15:0]       ImemData,
    output logic [ADDR_W-1:0] addr_to_write,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);

    localparam logic [15:0] MAX_WORDS    = 16'(1 << ADDR_W);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
    } state_t;

    state_t            state, state_next;
    logic [7:0]        len_hi;
    logic [7:0]        data_hi;
    logic [7:0]        checksum;
    logic [15:0]       words_left;
    logic [15:0]       tcnt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       len_full;
    logic              len_bad;
    logic              timeout_hit;

    assign len_full    = {len_hi, rx_data};
    assign len_bad     = (len_full == 16'd0) || (len_full > MAX_WORDS);
    // A byte arriving on the expiring cycle wins, so expiry requires an idle cycle.
    assign timeout_hit = busy && !rx_valid && (tcnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = !(state == IDLE || state == DONE || state == ERR);
        cpu_hold   = (state != DONE);
        load_err   = (state == ERR);
        if (timeout_hit) begin
            state_next = ERR;
        end else if (rx_valid) begin
            case (state)
                IDLE, DONE, ERR: if (rx_data == MAGIC) state_next = LEN_HI;
                LEN_HI:          state_next = LEN_LO;
                LEN_LO:          state_next = len_bad ? ERR : DATA_HI;
                DATA_HI:         state_next = DATA_LO;
                DATA_LO:         state_next = (words_left == 16'd1) ? CHECK : DATA_HI;
                CHECK:           state_next = (rx_data == checksum) ? DONE : ERR;
                default:         state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ImemWrite     <= 1'b0;
            ImemData      <= 16'd0;
            addr_to_write <= '0;
            load_done     <= 1'b0;
            len_hi        <= 8'd0;
            data_hi       <= 8'd0;
            checksum      <= 8'd0;
            words_left    <= 16'd0;
            tcnt          <= 16'd0;
            addr          <= '0;
        end else begin
            ImemWrite <= 1'b0;
            load_done <= 1'b0;

            if (!busy || rx_valid || timeout_hit) begin
                tcnt <= 16'd0;
            end else begin
                tcnt <= tcnt + 16'd1;
            end

            if (rx_valid) begin
                case (state)
                    IDLE, DONE, ERR: begin
                        if (rx_data == MAGIC) begin
                            checksum <= 8'd0;
                            addr     <= '0;
                        end
                    end
                    LEN_HI: len_hi <= rx_data;
                    LEN_LO: words_left <= len_full;
                    DATA_HI: begin
                        data_hi  <= rx_data;
                        checksum <= checksum ^ rx_data;
                    end
                    DATA_LO: begin
                        checksum      <= checksum ^ rx_data;
                        ImemWrite     <= 1'b1;
                        ImemData      <= {data_hi, rx_data};
                        addr_to_write <= addr;
                        words_left    <= words_left - 16'd1;
                        // Hold the address on the final word so it never wraps inside a frame.
                        if (words_left != 16'd1) addr <= addr + 1'b1;
                    end
                    CHECK: if (rx_data == checksum) load_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader framed program loading
module tb_imem_loader;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              ImemWrite;
    logic [15:0]       ImemData;
    logic [ADDR_W-1:0] addr_to_write;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic              busy;

    imem_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .ImemWrite     (ImemWrite),
        .ImemData      (ImemData),
        .addr_to_write (addr_to_write),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_err      (load_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                done;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] frame_words[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void push_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        exp_t e;
        e.done = 1'b0;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done();
        exp_t e;
        e.done = 1'b1;
        e.addr = '0;
        e.data = 16'd0;
        exp_q.push_back(e);
    endfunction

    // Monitor: every write strobe and done pulse must match the next expected event.
    exp_t mon_e;
    always @(negedge clk) begin
        if (ImemWrite) begin
            n_checks++;
            if (exp_q.size() == 0 || exp_q[0].done) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", addr_to_write, ImemData);
            end else begin
                mon_e = exp_q.pop_front();
                if (addr_to_write !== mon_e.addr || ImemData !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                             addr_to_write, ImemData, mon_e.addr, mon_e.data);
                end
            end
        end
        if (load_done) begin
            n_checks++;
            if (exp_q.size() == 0 || !exp_q[0].done) begin
                n_fail++;
                $display("FAIL unexpected_load_done: got 1, expected 0");
            end else begin
                mon_e = exp_q.pop_front();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr"},   32'(ImemWrite), 32'd0);
        check({tag, "_data"}, 32'(ImemData), 32'd0);
        check({tag, "_addr"}, 32'(addr_to_write), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"},  32'(load_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Sends A5, length, frame_words, checksum; bad_ck corrupts the checksum (41 -> 42 style).
    task automatic frame_send(input bit bad_ck);
        logic [7:0] ck;
        int         n;
        ck = 8'd0;
        n  = frame_words.size();
        for (int i = 0; i < n; i++) begin
            ck = ck ^ frame_words[i][15:8] ^ frame_words[i][7:0];
            push_write(ADDR_W'(i), frame_words[i]);
        end
        if (!bad_ck) push_done();
        send_byte(8'hA5);
        check("frame_start_hold", 32'(cpu_hold), 32'd1);
        check("frame_start_busy", 32'(busy), 32'd1);
        check("frame_start_err",  32'(load_err), 32'd0);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < n; i++) begin
            send_byte(frame_words[i][15:8]);
            send_byte(frame_words[i][7:0]);
        end
        send_byte(bad_ck ? (ck ^ 8'h03) : ck);
        check("frame_end_hold", 32'(cpu_hold), 32'(bad_ck));
        check("frame_end_err",  32'(load_err), 32'(bad_ck));
        check("frame_end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Good load: A5 00 03 12 34 AB CD 00 01 41
        frame_words = '{16'h1234, 16'hABCD, 16'h0001};
        frame_send(1'b0);
        tick();

        // Bad checksum (42), then a good frame clears the error
        frame_send(1'b1);
        tick();
        frame_send(1'b0);
        tick();

        // Length errors
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check("len0_err",  32'(load_err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
        check("len513_err",  32'(load_err), 32'd1);
        check("len513_hold", 32'(cpu_hold), 32'd1);

        // Maximum frame: 512 words, includes A5 bytes as data
        frame_words.delete();
        for (int i = 0; i < 512; i++) frame_words.push_back(16'(i * 16'h0301 + 16'hA5A5));
        frame_send(1'b0);
        tick();

        // Timeout: A5 00 02 12 then idle
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        repeat (TIMEOUT - 1) tick();
        check("timeout_before", 32'(load_err), 32'd0);
        tick();
        check("timeout_at", 32'(load_err), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);

        // Byte on the expiring cycle wins and the load continues
        push_write(9'h000, 16'h1234);
        push_write(9'h001, 16'hABCD);
        push_done();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        repeat (TIMEOUT - 1) tick();
        send_byte(8'h34);
        check("late_byte_err",  32'(load_err), 32'd0);
        check("late_byte_busy", 32'(busy), 32'd1);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h40);
        check("late_load_hold", 32'(cpu_hold), 32'd0);
        tick();

        // Noise ignored, then load and reload overwriting from address 0
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("noise_busy", 32'(busy), 32'd0);
        check("noise_hold", 32'(cpu_hold), 32'd0);
        frame_words = '{16'h0BAD, 16'hF00D};
        frame_send(1'b0);
        tick();
        frame_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        frame_send(1'b0);
        tick();

        // Reset right after the second write of a 3-word frame
        push_write(9'h000, 16'h5678);
        push_write(9'h001, 16'h9ABC);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A); send_byte(8'hBC);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midreset");
        send_byte(8'hDE); send_byte(8'hF0); send_byte(8'h00);
        check("midreset_busy_after", 32'(busy), 32'd0);
        frame_words = '{16'hCAFE, 16'hBEEF, 16'h0042};
        frame_send(1'b0);

        repeat (4) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-serial program loader that sits directly upstream of the CPU's instruction-memory write port.
- Receives a framed program image from the serial receiver (SPART RX): magic byte, 16-bit word count, big-endian instruction words, then an XOR checksum.
- Drives ImemWrite/ImemData/addr_to_write, one write per word.
- Holds the CPU stalled until a frame loads cleanly; replaces the current hand-driven ImemWrite stimulus.

Parameters:
- ADDR_W, 9: instruction-memory word-address width. Maximum legal word count is 2^ADDR_W.
- MAGIC, 8'hA5: frame start byte.
- TIMEOUT, 50000: inter-byte timeout in cycles, mid-frame. Counter is 16 bits; TIMEOUT must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe; byte accepted that cycle. No backpressure.
- ImemWrite  out  1  one-cycle instruction-memory write strobe.
- ImemData  out  16  instruction word to write.
- addr_to_write  out  ADDR_W  word address of the write.
- cpu_hold  out  1  1 = keep CPU stalled/in reset (no valid program).
- load_done  out  1  one-cycle pulse on successful frame completion.
- load_err  out  1  sticky error flag; cleared when the next frame starts.
- busy  out  1  1 while a frame is in progress (any state other than IDLE/DONE/ERR).

Behaviour:
- Reset values:
  - ImemWrite=0, ImemData=0, addr_to_write=0.
  - cpu_hold=1, load_done=0, load_err=0, busy=0.
  - state=IDLE, checksum=0, word counter=0, timeout counter=0.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
- All state changes happen only on accepted bytes (rx_valid=1), except timeout.
- IDLE/DONE/ERR:
  - Byte == MAGIC → LEN_HI, busy=1, load_err=0, cpu_hold=1, checksum=0, address=0.
  - Any other byte is ignored.
- LEN_HI: latch count[15:8] → LEN_LO.
- LEN_LO: latch count[7:0].
  - count==0 or count>2^ADDR_W → ERR.
  - Otherwise → DATA_HI.
- DATA_HI: latch high byte, XOR it into checksum → DATA_LO.
- DATA_LO: XOR low byte into checksum.
  - Next cycle: ImemWrite=1, ImemData={hi,lo}, addr_to_write=current address. Address increments afterward.
  - Remaining count decrements. If it reaches 0 → CHECK, else → DATA_HI.
  - addr_to_write holds its last value when ImemWrite=0.
- CHECK: compare rx_data to running checksum (XOR of all payload bytes only; magic and length excluded).
  - Match → DONE. The following cycle load_done=1 for one cycle and cpu_hold=0.
  - Mismatch → ERR. load_err=1, cpu_hold stays 1. Words already written are not undone.
- ERR: load_err=1, cpu_hold=1, busy=0. Left only via MAGIC (restart) or rst.
- DONE: cpu_hold=0 is held. A new MAGIC reasserts cpu_hold the next cycle (reload).
- Timeout (states LEN_HI..CHECK only):
  - Counter clears on every accepted byte and increments on every cycle without rx_valid.
  - When it reaches TIMEOUT, state → ERR and load_err rises on that edge.
  - rx_valid in the cycle the counter would reach TIMEOUT wins: byte accepted, counter cleared.
- Frame containing MAGIC bytes as data: treated as data. Magic detection applies in IDLE/DONE/ERR only.
- Max frame: count=2^ADDR_W writes addresses 0..2^ADDR_W-1. The address counter never wraps within a frame.
- Reset mid-frame: everything returns to reset values the next edge, no further writes. The next frame starts at address 0.
- Write-to-next-byte spacing: one write is generated per two accepted bytes, so back-to-back rx_valid every cycle is legal.

Test Plan:
- Good load: bytes A5 00 03 12 34 AB CD 00 01 41 on consecutive cycles.
  - Writes (addr 0,1234), (1,ABCD), (2,0001), each a one-cycle ImemWrite.
  - load_done one-cycle pulse, cpu_hold 1→0, load_err=0.
- Bad checksum: same frame ending 42.
  - Same three writes occur; load_err=1, cpu_hold=1, no load_done.
  - A following good frame clears load_err and completes.
- Length errors:
  - A5 00 00 → ERR right after the length byte, zero writes.
  - A5 02 01 (513 > 512) → ERR, zero writes.
  - A5 02 00 with 512 words and correct checksum → last write at addr 1FF, load_done.
- Timeout: A5 00 02 12 then idle.
  - load_err rises exactly TIMEOUT cycles after the 12 byte.
  - Repeat with a byte on cycle TIMEOUT-1 → no error, load continues.
- Noise then reload:
  - 00 FF 5A ignored, then a good frame loads normally.
  - After DONE, another A5 reasserts cpu_hold and a second frame overwrites from addr 0.
- Reset mid-load: assert rst for 1 cycle after the second ImemWrite of a 3-word frame.
  - All outputs at reset values, no third write.
  - A new good frame writes starting at addr 0.
